mem_stage_lsu: RTL
==================

# mem_stage_lsu

Memory-stage load/store unit of the pipelined CPU. It consumes the EXE/MEM pipeline register outputs and issues loads and stores to a variable-latency data-memory port over a request/grant/response handshake. It stalls the front of the pipeline while an access is outstanding and delivers a registered write-back bundle (the MEM/WB stage) to the register file.

## Interface
Parameters:
- BIT_WIDTH, 32: data and address width.
- REG_INDEX_BIT_WIDTH, 4: register-index width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- mem_wrt_en  in  1  store request from EXE/MEM.
- reg_file_wrt_en  in  1  instruction writes a register.
- dst_mux  in  2  write-back source: 00 ALU, 01 memory (load), 10 link (uses alu_res), 11 treated as 00.
- dst_ind  in  REG_INDEX_BIT_WIDTH  destination register.
- alu_res  in  BIT_WIDTH  memory byte address, or write-back value.
- src1  in  BIT_WIDTH  store data.
- stall  out  1  combinational; 1 = upstream must hold the EXE/MEM register and PC (EXE/MEM `en` = ~stall).
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  BIT_WIDTH  = alu_res, passed through unmodified.
- dmem_wdata  out  BIT_WIDTH  = src1.
- dmem_gnt  in  1  memory accepts the request this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  BIT_WIDTH  load data.
- wb_en  out  1  registered register-file write enable.
- wb_ind  out  REG_INDEX_BIT_WIDTH  registered destination index.
- wb_data  out  BIT_WIDTH  registered write-back value.

## Operation
- Classification:
  - store = mem_wrt_en.
  - load = reg_file_wrt_en & dst_mux==01 & ~mem_wrt_en. If both are set, the store wins and the register write is suppressed.
  - otherwise the instruction is pass-through.
- FSM states: IDLE, WAIT_GNT, WAIT_DATA.
  - IDLE: a load/store drives dmem_req=1 in the same cycle.
    - gnt=1 on a store: done.
    - gnt=1 on a load: go to WAIT_DATA.
    - gnt=0: go to WAIT_GNT.
  - WAIT_GNT: dmem_req is held at 1 with stable we/addr/wdata.
    - gnt on a store: done, go to IDLE.
    - gnt on a load: go to WAIT_DATA.
  - WAIT_DATA: dmem_req=0. On rvalid: done, go to IDLE.
- Loads complete no earlier than the cycle after the grant. dmem_rvalid in IDLE or WAIT_GNT is ignored.
- stall = (load or store present) & ~done_this_cycle. Pass-through instructions never stall.
- Write-back register update, every clock edge:
  - stall=0: wb_en <= reg_file_wrt_en & ~mem_wrt_en; wb_ind <= dst_ind; wb_data <= (load ? dmem_rdata : alu_res).
  - stall=1: wb_en <= 0 (bubble); wb_ind and wb_data hold.
- Bubble input (both enables 0) produces wb_en=0 on the next cycle.

## Timing
- Reset values: state=IDLE; wb_en=0; wb_ind=0; wb_data=0. Combinational outputs settle to dmem_req=0 and stall=0 only when inputs are a bubble.
- Pass-through instruction: wb_* valid 1 cycle after it is presented.
- Store with gnt in the first cycle: 0 stall cycles, wb_en=0 next cycle. Each cycle gnt is late adds 1 stall cycle.
- Load: stall cycles = (gnt delay) + 1 + (cycles from grant to rvalid − 1); wb_data captured at the rvalid edge.
- Reset asserted mid-access: immediate return to IDLE and outputs to reset values. The outstanding memory response is dropped, and the memory side must tolerate the abandoned request.
- Upstream must hold inputs stable while stall=1. Changed inputs during a stall are undefined.

## Structure
- Shared package `cpu_pkg`:
  - DST_MUX_ALU/MEM/LINK encodings
  - lsu_state_t enum (IDLE, WAIT_GNT, WAIT_DATA)
  - BIT_WIDTH and REG_INDEX_BIT_WIDTH defaults
- Sub-module `lsu_fsm`: state register, done/stall generation and dmem_req. The top level holds classification and the write-back registers.

## Test plan
- ALU op (reg_file_wrt_en=1, dst_mux=00, dst_ind=3, alu_res=0x1234) -> next cycle wb_en=1, wb_ind=3, wb_data=0x1234, stall=0 throughout.
- Store addr=0x40, src1=0xDEADBEEF, gnt delayed 2 cycles -> dmem_req=1/we=1 for 3 cycles, stall=1 for 2 cycles, then wb_en=0.
- Load addr=0x80 into r5, gnt immediate, rvalid 3 cycles later with 0xCAFEF00D -> stall=1 for 3 cycles, then wb_en=1, wb_ind=5, wb_data=0xCAFEF00D.
- Spurious dmem_rvalid in IDLE during an ALU op -> wb_data=alu_res, no state change.
- Reset pulled low while in WAIT_DATA -> wb_en=0, wb_data=0, state IDLE; a late rvalid after release is ignored.
- mem_wrt_en=1 together with reg_file_wrt_en=1 and dst_mux=01 -> store issued, wb_en=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back source encodings, LSU state type and default widths.
package cpu_pkg;

   localparam int unsigned DEFAULT_BIT_WIDTH           = 32;
   localparam int unsigned DEFAULT_REG_INDEX_BIT_WIDTH = 4;

   localparam logic [1:0] DST_MUX_ALU  = 2'b00;
   localparam logic [1:0] DST_MUX_MEM  = 2'b01;
   localparam logic [1:0] DST_MUX_LINK = 2'b10;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_GNT  = 2'd1,
      WAIT_DATA = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/lsu_fsm.sv
// Data-memory handshake sequencer: tracks the outstanding access and produces
// the request strobe and the pipeline stall.
module lsu_fsm
   import cpu_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic store_i,
   input  logic gnt_i,
   input  logic rvalid_i,
   output logic stall_o,
   output logic req_o
);

   lsu_state_t state_q, state_d;
   logic       access;
   logic       done;

   always_comb begin
      access  = load_i | store_i;
      state_d = state_q;
      req_o   = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            req_o = access;
            if (access) begin
               if (gnt_i) begin
                  done = store_i;
                  if (load_i) state_d = WAIT_DATA;
               end else begin
                  state_d = WAIT_GNT;
               end
            end
         end
         WAIT_GNT: begin
            req_o = access;
            if (!access) begin
               state_d = IDLE;
            end else if (gnt_i) begin
               done    = store_i;
               state_d = load_i ? WAIT_DATA : IDLE;
            end
         end
         WAIT_DATA: begin
            // rvalid is only honoured here, so a load never completes on its grant cycle
            if (rvalid_i) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      stall_o = access & ~done;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: classifies the EXE/MEM instruction, drives the
// data-memory port and holds the MEM/WB write-back register.
module mem_stage_lsu
   import cpu_pkg::*;
#(
   parameter int unsigned BIT_WIDTH           = DEFAULT_BIT_WIDTH,
   parameter int unsigned REG_INDEX_BIT_WIDTH = DEFAULT_REG_INDEX_BIT_WIDTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           mem_wrt_en,
   input  logic                           reg_file_wrt_en,
   input  logic [1:0]                     dst_mux,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind,
   input  logic [BIT_WIDTH-1:0]           alu_res,
   input  logic [BIT_WIDTH-1:0]           src1,
   output logic                           stall,
   output logic                           dmem_req,
   output logic                           dmem_we,
   output logic [BIT_WIDTH-1:0]           dmem_addr,
   output logic [BIT_WIDTH-1:0]           dmem_wdata,
   input  logic                           dmem_gnt,
   input  logic                           dmem_rvalid,
   input  logic [BIT_WIDTH-1:0]           dmem_rdata,
   output logic                           wb_en,
   output logic [REG_INDEX_BIT_WIDTH-1:0] wb_ind,
   output logic [BIT_WIDTH-1:0]           wb_data
);

   logic                           is_store;
   logic                           is_load;
   logic [BIT_WIDTH-1:0]           wb_sel;
   logic                           wb_en_q,   wb_en_d;
   logic [REG_INDEX_BIT_WIDTH-1:0] wb_ind_q,  wb_ind_d;
   logic [BIT_WIDTH-1:0]           wb_data_q, wb_data_d;

   // A store wins over a simultaneous load encoding
   assign is_store = mem_wrt_en;
   assign is_load  = reg_file_wrt_en & (dst_mux == DST_MUX_MEM) & ~mem_wrt_en;

   lsu_fsm u_fsm (
      .clk      (clk),
      .reset    (reset),
      .load_i   (is_load),
      .store_i  (is_store),
      .gnt_i    (dmem_gnt),
      .rvalid_i (dmem_rvalid),
      .stall_o  (stall),
      .req_o    (dmem_req)
   );

   assign dmem_we    = is_store;
   assign dmem_addr  = alu_res;
   assign dmem_wdata = src1;

   always_comb begin
      wb_sel = alu_res;
      case (dst_mux)
         DST_MUX_MEM: if (is_load) wb_sel = dmem_rdata;
         default:     wb_sel = alu_res;
      endcase
   end

   always_comb begin
      wb_en_d   = 1'b0;
      wb_ind_d  = wb_ind_q;
      wb_data_d = wb_data_q;
      if (!stall) begin
         wb_en_d   = reg_file_wrt_en & ~mem_wrt_en;
         wb_ind_d  = dst_ind;
         wb_data_d = wb_sel;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_en_q   <= 1'b0;
         wb_ind_q  <= '0;
         wb_data_q <= '0;
      end else begin
         wb_en_q   <= wb_en_d;
         wb_ind_q  <= wb_ind_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign wb_en   = wb_en_q;
   assign wb_ind  = wb_ind_q;
   assign wb_data = wb_data_q;

endmodule
